nec_key_filter: RTL and testbench

//   Downstream of the NEC pulse-distance decoder. Takes its 32-bit frame, load and repeat strobes.

---
 rtl/nec_pkg.sv | 38 +++
 rtl/nec_key_fifo.sv | 75 +++++++
 rtl/nec_key_filter.sv | 215 +++++++++++++++++++++
 tb/tb_nec_key_filter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_pkg.sv
// ----------------------------------------------------------------------------
// nec_pkg
//   Shared definitions for the NEC key filter slice:
//     - bit positions of the four NEC bytes inside the decoder shift register
//     - key event layout pushed into the FIFO ({rep, addr16, cmd8})
//     - repeat-window state encoding
//     - rev8(): byte bit-reversal (NEC sends each byte LSB first, the decoder
//       shifts MSB first, so every byte arrives mirrored)
// ----------------------------------------------------------------------------
package nec_pkg;

    localparam int ADDR_MSB  = 31;
    localparam int NADDR_MSB = 23;
    localparam int CMD_MSB   = 15;
    localparam int NCMD_MSB  = 7;

    typedef struct packed {
        logic        rep;
        logic [15:0] addr;
        logic [7:0]  cmd;
    } key_event_t;

    localparam int KEY_W = $bits(key_event_t);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } rep_state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/nec_key_fifo.sv
// ----------------------------------------------------------------------------
// nec_key_fifo
//   Synchronous first-word-fall-through FIFO for key events.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (flushes the FIFO)
//     push_i, din_i   write request and data; ignored when full unless a pop
//                     happens in the same cycle
//     full_o          FIFO holds DEPTH entries
//     pop_i           remove head (ignored when empty)
//     dout_o          head entry, forced to 0 while empty
//     empty_o         no entries
//   DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module nec_key_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push_i && (!full_o || do_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= din_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/nec_key_filter.sv
// ----------------------------------------------------------------------------
// nec_key_filter
//   Sits behind the NEC pulse-distance decoder. Detects rising edges of the
//   decoder's load and repeat levels, validates the inversion bytes of a
//   frame, bit-reverses the fields and qualifies repeat codes against a
//   timed window. Accepted key events are buffered in nec_key_fifo and
//   presented with a valid/ready handshake.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     frame_data    decoder shift register, MSB = first received bit
//     frame_load    decoder load level (rising edge = new frame)
//     frame_rep     decoder repeat level (rising edge = repeat code)
//     key_valid     FIFO head valid
//     key_ready     consumer takes the head when key_valid & key_ready
//     key_addr      16-bit address of head event
//     key_cmd       command of head event
//     key_repeat    head event came from a repeat code
//     err_count     saturating count of frames failing the inversion check
//     ovf_count     saturating count of events dropped on a full FIFO
//   Configuration macro: NEC_EXT_ADDR_EN
//     defined   -> extended NEC: second byte is the address high byte and
//                  only the command inversion is checked
//     undefined -> address high byte 0, both inversions checked
// ----------------------------------------------------------------------------
module nec_key_filter
    import nec_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int CLK_PER_MS    = 1000,
    parameter int REP_WINDOW_MS = 120,
    parameter int REP_SKIP      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] frame_data,
    input  logic        frame_load,
    input  logic        frame_rep,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [15:0] key_addr,
    output logic [7:0]  key_cmd,
    output logic        key_repeat,
    output logic [7:0]  err_count,
    output logic [7:0]  ovf_count
);

    localparam int         WIN_CYCLES = REP_WINDOW_MS * CLK_PER_MS;
    localparam int         TW         = $clog2(WIN_CYCLES + 1);
    localparam logic [3:0] SKIP_N     = 4'(REP_SKIP);

    // ---------------- edge detection ----------------
    // History regs reset to 1 so a level already high out of reset is not
    // mistaken for a new event.
    logic        load_prev_q;
    logic        rep_prev_q;
    logic        load_evt_q;
    logic        rep_evt_q;
    logic [31:0] data_q;
    logic        load_rise;
    logic        rep_rise;

    assign load_rise = frame_load & ~load_prev_q;
    assign rep_rise  = frame_rep & ~rep_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_prev_q <= 1'b1;
            rep_prev_q  <= 1'b1;
            load_evt_q  <= 1'b0;
            rep_evt_q   <= 1'b0;
            data_q      <= '0;
        end else begin
            load_prev_q <= frame_load;
            rep_prev_q  <= frame_rep;
            load_evt_q  <= load_rise;
            // A frame arriving together with a repeat wins; the repeat is lost.
            rep_evt_q   <= rep_rise & ~load_rise;
            if (load_rise) begin
                data_q <= frame_data;
            end
        end
    end

    // ---------------- frame check ----------------
    logic [7:0]  f_a;
    logic [7:0]  f_na;
    logic [7:0]  f_c;
    logic [7:0]  f_nc;
    logic [15:0] f_addr;
    logic        frame_ok;

    assign f_a  = rev8(data_q[ADDR_MSB  -: 8]);
    assign f_na = rev8(data_q[NADDR_MSB -: 8]);
    assign f_c  = rev8(data_q[CMD_MSB   -: 8]);
    assign f_nc = rev8(data_q[NCMD_MSB  -: 8]);

`ifdef NEC_EXT_ADDR_EN
    assign f_addr   = {f_na, f_a};
    assign frame_ok = (f_c == ~f_nc);
`else
    assign f_addr   = {8'h00, f_a};
    assign frame_ok = (f_c == ~f_nc) && (f_a == ~f_na);
`endif

    // ---------------- repeat window FSM ----------------
    rep_state_t  state_q;
    logic [TW-1:0] timer_q;
    logic [3:0]  rep_cnt_q;
    logic [23:0] last_q;
    logic        rep_take;

    assign rep_take = rep_evt_q && (state_q == S_HELD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            rep_cnt_q <= '0;
            last_q    <= '0;
        end else begin
            // Window countdown; an accepted frame/repeat below overrides it.
            if (state_q == S_HELD) begin
                if (timer_q <= TW'(1)) begin
                    state_q <= S_IDLE;
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q - 1'b1;
                end
            end
            if (load_evt_q && frame_ok) begin
                state_q   <= S_HELD;
                timer_q   <= TW'(WIN_CYCLES);
                rep_cnt_q <= '0;
                last_q    <= {f_addr, f_c};
            end else if (rep_take) begin
                state_q <= S_HELD;
                timer_q <= TW'(WIN_CYCLES);
                if (rep_cnt_q < SKIP_N) begin
                    rep_cnt_q <= rep_cnt_q + 1'b1;
                end
            end
        end
    end

    // ---------------- push request ----------------
    logic       push_req;
    key_event_t push_ev;

    always_comb begin
        push_req = 1'b0;
        push_ev  = '0;
        if (load_evt_q) begin
            push_req     = frame_ok;
            push_ev.rep  = 1'b0;
            push_ev.addr = f_addr;
            push_ev.cmd  = f_c;
        end else if (rep_take && (rep_cnt_q >= SKIP_N)) begin
            push_req                  = 1'b1;
            push_ev.rep               = 1'b1;
            {push_ev.addr, push_ev.cmd} = last_q;
        end
    end

    // ---------------- FIFO ----------------
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [KEY_W-1:0] fifo_dout;
    key_event_t       head_ev;

    assign fifo_pop = ~fifo_empty & key_ready;

    nec_key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .din_i   (push_ev),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty)
    );

    assign head_ev    = key_event_t'(fifo_dout);
    assign key_valid  = ~fifo_empty;
    assign key_addr   = head_ev.addr;
    assign key_cmd    = head_ev.cmd;
    assign key_repeat = head_ev.rep;

    // ---------------- status counters ----------------
    logic [7:0] err_count_q;
    logic [7:0] ovf_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
            ovf_count_q <= '0;
        end else begin
            if (load_evt_q && !frame_ok && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 1'b1;
            end
            // Dropped only when full and no simultaneous pop makes room.
            if (push_req && fifo_full && !fifo_pop && (ovf_count_q != 8'hFF)) begin
                ovf_count_q <= ovf_count_q + 1'b1;
            end
        end
    end

    assign err_count = err_count_q;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_nec_key_filter.sv
module tb_nec_key_filter;

    localparam int DEPTH = 4;
    localparam int CPM   = 10;
    localparam int WMS   = 120;
    localparam int SKIP  = 1;
    localparam int WIN   = WMS * CPM;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] frame_data = '0;
    logic        frame_load = 1'b0;
    logic        frame_rep  = 1'b0;
    logic        key_ready  = 1'b0;
    logic        key_valid;
    logic [15:0] key_addr;
    logic [7:0]  key_cmd;
    logic        key_repeat;
    logic [7:0]  err_count;
    logic [7:0]  ovf_count;

    nec_key_filter #(
        .FIFO_DEPTH    (DEPTH),
        .CLK_PER_MS    (CPM),
        .REP_WINDOW_MS (WMS),
        .REP_SKIP      (SKIP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_data (frame_data),
        .frame_load (frame_load),
        .frame_rep  (frame_rep),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_addr   (key_addr),
        .key_cmd    (key_cmd),
        .key_repeat (key_repeat),
        .err_count  (err_count),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        rep;
        logic [15:0] addr;
        logic [7:0]  cmd;
    } ev_t;

    ev_t exp_q[$];
    bit  have_last   = 0;
    ev_t last_ev     = '0;
    int  last_reload = 0;
    int  rep_cnt     = 0;
    int  m_err       = 0;
    int  m_ovf       = 0;
    int  pops        = 0;
    int  rep_pops    = 0;
    int  ready_mode  = 1;   // 0: never ready, 1: always ready, 2: random

    function automatic logic [7:0] rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] na,
                                       input logic [7:0] c, input logic [7:0] nc);
        return {rev(a), rev(na), rev(c), rev(nc)};
    endfunction

    task automatic model_push(input ev_t e);
        if (exp_q.size() >= DEPTH) begin
            if (m_ovf < 255) m_ovf++;
        end else begin
            exp_q.push_back(e);
        end
    endtask

    // Called once the DUT has processed the event (check cycle = cyc).
    task automatic model_event(input bit l, input bit r, input logic [31:0] d);
        logic [7:0] a, na, c, nc;
        bit ok;
        ev_t e;
        a  = rev(d[31:24]);
        na = rev(d[23:16]);
        c  = rev(d[15:8]);
        nc = rev(d[7:0]);
        if (l) begin
`ifdef NEC_EXT_ADDR_EN
            ok = ((c ^ nc) == 8'hFF);
            e  = '{rep: 1'b0, addr: {na, a}, cmd: c};
`else
            ok = ((c ^ nc) == 8'hFF) && ((a ^ na) == 8'hFF);
            e  = '{rep: 1'b0, addr: {8'h00, a}, cmd: c};
`endif
            if (ok) begin
                model_push(e);
                have_last   = 1;
                last_ev     = e;
                last_reload = cyc;
                rep_cnt     = 0;
            end else if (m_err < 255) begin
                m_err++;
            end
        end else if (r) begin
            if (have_last && (cyc - last_reload) <= WIN) begin
                last_reload = cyc;
                if (rep_cnt < SKIP) begin
                    rep_cnt++;
                end else begin
                    e     = last_ev;
                    e.rep = 1'b1;
                    model_push(e);
                end
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        have_last = 0;
        rep_cnt   = 0;
        m_err     = 0;
        m_ovf     = 0;
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            key_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    ev_t prev_head;
    bit  prev_stall = 0;

    always @(negedge clk) begin
        ev_t got, e;
        got = '{rep: key_repeat, addr: key_addr, cmd: key_cmd};
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(key_valid), 32'd1);
                chk("hold_head", 32'(got), 32'(prev_head));
            end
            if (key_valid && key_ready) begin
                pops++;
                if (got.rep) rep_pops++;
                $display("txn @%0d addr=%04h cmd=%02h rep=%0d", cyc, got.addr, got.cmd, got.rep);
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("event", 32'(got), 32'(e));
                end
            end
            prev_stall = key_valid && !key_ready;
            prev_head  = got;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_until(input int target);
        while (cyc < target - 2) @(negedge clk);
    endtask

    // Entered and left on a falling clock edge.
    task automatic send(input bit l, input bit r, input logic [31:0] d,
                        input int hold, input bit lat, output int chk_cyc);
        frame_data = d;
        frame_load = l;
        frame_rep  = r;
        @(posedge clk); #1;
        if (lat) chk("latency_e0", 32'(key_valid), 32'd0);
        @(posedge clk); #1;
        model_event(l, r, d);
        chk_cyc = cyc;
        if (lat) chk("latency_e1", 32'(key_valid), 32'd1);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        frame_load = 1'b0;
        frame_rep  = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int c0, cprev, p0, r0, target, k, gap;
        logic [7:0] a, c, na, nc;

        // Reset with load already high: no event may appear afterwards.
        frame_load = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_head", {7'b0, key_repeat, key_addr, key_cmd}, 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_ovf", 32'(ovf_count), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_evt_after_rst", 32'(key_valid), 32'd0);
        frame_load = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame, latency check.
        ready_mode = 1;
        send(1, 0, mk(8'h04, 8'hFB, 8'h08, 8'hF7), 0, 1, c0);
        drain("drain_basic");

        // Command inversion wrong.
        send(1, 0, mk(8'h04, 8'hFB, 8'h08, 8'h08), 0, 0, c0);
        repeat (4) @(negedge clk);
        chk("bad_no_valid", 32'(key_valid), 32'd0);
        chk("err_count_1", 32'(err_count), 32'(m_err));

        // Frame then three repeats 108 ms apart: first one skipped.
        p0 = pops; r0 = rep_pops;
        send(1, 0, mk(8'h04, 8'hFB, 8'h08, 8'hF7), 0, 0, cprev);
        for (int i = 0; i < 3; i++) begin
            wait_until(cprev + 108 * CPM);
            send(0, 1, 32'h0, 0, 0, cprev);
        end
        drain("drain_rep");
        chk("rep_events", rep_pops - r0, 2);
        chk("rep_total", pops - p0, 3);

        // Repeat 130 ms after a frame is ignored.
        send(1, 0, mk(8'h21, 8'hDE, 8'h42, 8'hBD), 0, 0, c0);
        drain("drain_late_frame");
        p0 = pops;
        wait_until(c0 + 130 * CPM);
        send(0, 1, 32'h0, 0, 0, c0);
        repeat (6) @(negedge clk);
        chk("late_rep_valid", 32'(key_valid), 32'd0);
        chk("late_rep_pops", pops - p0, 0);

        // Overflow: six frames with consumer stalled.
        ready_mode = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            a = 8'(8'h30 + i);
            c = 8'(8'h50 + 3 * i);
            send(1, 0, mk(a, ~a, c, ~c), 0, 0, c0);
        end
        repeat (10) @(negedge clk);
        chk("ovf_valid", 32'(key_valid), 32'd1);
        chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
        chk("ovf_queued", exp_q.size(), DEPTH);
        ready_mode = 1;
        drain("drain_ovf");

        // Load held for 1000 cycles gives a single event.
        p0 = pops;
        send(1, 0, mk(8'h77, 8'h88, 8'h19, 8'hE6), 1000, 0, c0);
        drain("drain_hold");
        chk("hold_one_event", pops - p0, 1);

        // Simultaneous load and repeat edges.
        p0 = pops;
        send(1, 0, mk(8'h0A, 8'hF5, 8'h11, 8'hEE), 0, 0, c0);
        send(0, 1, 32'h0, 0, 0, c0);
        send(1, 1, mk(8'h0B, 8'hF4, 8'h22, 8'hDD), 0, 0, c0);
        send(0, 1, 32'h0, 0, 0, c0);
        send(0, 1, 32'h0, 0, 0, c0);
        drain("drain_simul");
        chk("simul_events", pops - p0, 3);

`ifdef NEC_EXT_ADDR_EN
        ready_mode = 0;
        repeat (2) @(negedge clk);
        send(1, 0, mk(8'h12, 8'h34, 8'h55, 8'hAA), 0, 0, c0);
        repeat (2) @(negedge clk);
        chk("ext_addr", 32'(key_addr), 32'h3412);
        ready_mode = 1;
        drain("drain_ext");
`endif

        // Randomised traffic with a randomly stalling consumer.
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            k   = $urandom_range(0, 9);
            gap = $urandom_range(3, 400);
            target = cyc + gap;
            if (have_last && (target - last_reload) >= WIN - 5 && (target - last_reload) <= WIN + 5)
                target += 20;
            wait_until(target);
            a = 8'($urandom);
            c = 8'($urandom);
            na = ~a;
            nc = ~c;
            if ($urandom_range(0, 9) < 3) begin
                if ($urandom_range(0, 1) == 1) nc = nc ^ (8'h01 << $urandom_range(0, 7));
                else                           na = na ^ (8'h01 << $urandom_range(0, 7));
            end
            if (k < 6)       send(1, 0, mk(a, na, c, nc), 0, 0, c0);
            else if (k < 9)  send(0, 1, 32'h0, 0, 0, c0);
            else             send(1, 1, mk(a, na, c, nc), 0, 0, c0);
        end
        ready_mode = 1;
        drain("drain_random");
        chk("rand_err", 32'(err_count), 32'(m_err));
        chk("rand_ovf", 32'(ovf_count), 32'(m_ovf));

        // Reset with a non-empty FIFO.
        ready_mode = 0;
        repeat (2) @(negedge clk);
        send(1, 0, mk(8'h01, 8'hFE, 8'h02, 8'hFD), 0, 0, c0);
        send(1, 0, mk(8'h03, 8'h03, 8'h04, 8'hFB), 0, 0, c0);
        chk("pre_rst_valid", 32'(key_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_flush_valid", 32'(key_valid), 32'd0);
        chk("rst_flush_err", 32'(err_count), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 1;
        // Window must be closed after reset: a repeat is ignored.
        p0 = pops;
        send(0, 1, 32'h0, 0, 0, c0);
        repeat (6) @(negedge clk);
        chk("rst_window_closed", pops - p0, 0);
        send(1, 0, mk(8'h04, 8'hFB, 8'h08, 8'hF7), 0, 0, c0);
        drain("drain_final");
        chk("final_err", 32'(err_count), 32'(m_err));
        chk("final_ovf", 32'(ovf_count), 32'(m_ovf));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
